// File: rtl/am_insert_sched.sv
// Purpose: carries multi-lane PCS beats and inserts one alignment marker with a per-lane BIP every 2^GAP_W-1 data beats.
// Latency: one cycle from an accepted upstream beat to the registered downstream beat; each marker slot takes one extra beat.
// Backpressure: in DATA up_ready_o follows the output-register load condition; it stays low while a marker is emitted.
module am_insert_sched #(
   parameter int LANE_N = 4,
   parameter int HEAD_W = 2,
   parameter int DATA_W = 64,
   parameter int GAP_W  = 14
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     up_valid_i,
   output logic                     up_ready_o,
   input  logic [LANE_N*HEAD_W-1:0] up_head_i,
   input  logic [LANE_N*DATA_W-1:0] up_data_i,
   output logic                     dn_valid_o,
   input  logic                     dn_ready_i,
   output logic [LANE_N*HEAD_W-1:0] dn_head_o,
   output logic [LANE_N*DATA_W-1:0] dn_data_o,
   output logic                     dn_marker_o
);

   typedef enum logic {S_MARK, S_DATA} state_t;

   state_t                    state_q, state_d;
   logic [GAP_W-1:0]          gap_q, gap_d, gap_inc;
   logic [LANE_N*8-1:0]       acc_q, acc_d;
   logic [LANE_N*8-1:0]       up_fold, mark_fold;
   logic [LANE_N*HEAD_W-1:0]  mark_head, head_d;
   logic [LANE_N*DATA_W-1:0]  mark_data, data_d;
   logic                      load, vld_d, mk_d;

   // 8-bit interleaved parity of one 66-bit block: payload bit k lands on bit k%8,
   // header bit 0 lands on bit 3 and header bit 1 on bit 4.
   function automatic logic [7:0] fold(input logic [HEAD_W-1:0] h, input logic [DATA_W-1:0] d);
      logic [7:0] f;
      f = '0;
      for (int m = 0; m < DATA_W/8; m++) begin
         f = f ^ d[m*8 +: 8];
      end
      f[3] = f[3] ^ h[0];
      f[4] = f[4] ^ h[1];
      return f;
   endfunction

   // Marker payload for one lane; fixed bytes M0..M2, M4..M6 with BIP in byte 3 and its inverse in byte 7.
   function automatic logic [63:0] marker_lane(input int lane, input logic [7:0] bip);
      logic [47:0] c;
      case (lane)
         0:       c = 48'h90_76_47_6F_89_B8;
         1:       c = 48'hF0_C4_E6_0F_3B_19;
         2:       c = 48'hC5_65_9B_3A_9A_64;
         3:       c = 48'hA2_79_3D_5D_86_C2;
         default: c = '0;
      endcase
      return {~bip, c[7:0], c[15:8], c[23:16], bip, c[31:24], c[39:32], c[47:40]};
   endfunction

   // Per-lane marker beat built from the running BIP, plus the parity folds of both candidate beats.
   always_comb begin
      mark_head = '0;
      mark_data = '0;
      mark_fold = '0;
      up_fold   = '0;
      for (int i = 0; i < LANE_N; i++) begin
         mark_head[i*HEAD_W +: HEAD_W] = HEAD_W'(1);
         mark_data[i*DATA_W +: DATA_W] = DATA_W'(marker_lane(i, acc_q[i*8 +: 8]));
         mark_fold[i*8 +: 8] = fold(mark_head[i*HEAD_W +: HEAD_W], mark_data[i*DATA_W +: DATA_W]);
         up_fold[i*8 +: 8]   = fold(up_head_i[i*HEAD_W +: HEAD_W], up_data_i[i*DATA_W +: DATA_W]);
      end
   end

   // Next state, output-register load and parity accumulation; only a freshly loaded beat is folded.
   always_comb begin
      load       = ~dn_valid_o | dn_ready_i;
      up_ready_o = (state_q == S_DATA) & load;
      gap_inc    = gap_q + GAP_W'(1);
      state_d    = state_q;
      gap_d      = gap_q;
      acc_d      = acc_q;
      vld_d      = dn_valid_o;
      mk_d       = dn_marker_o;
      head_d     = dn_head_o;
      data_d     = dn_data_o;
      if (state_q == S_MARK) begin
         if (load) begin
            vld_d   = 1'b1;
            mk_d    = 1'b1;
            head_d  = mark_head;
            data_d  = mark_data;
            acc_d   = mark_fold;
            gap_d   = '0;
            state_d = S_DATA;
         end
      end else begin
         if (load) begin
            if (up_valid_i) begin
               vld_d  = 1'b1;
               mk_d   = 1'b0;
               head_d = up_head_i;
               data_d = up_data_i;
               acc_d  = acc_q ^ up_fold;
               gap_d  = gap_inc;
               // Counter reaching all-ones means the last data beat of the interval was just taken.
               if (gap_inc == '1) begin
                  state_d = S_MARK;
               end
            end else begin
               vld_d = 1'b0;
               mk_d  = 1'b0;
            end
         end
      end
   end

   // State, counter, accumulators and the output register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_MARK;
         gap_q       <= '0;
         acc_q       <= '0;
         dn_valid_o  <= 1'b0;
         dn_marker_o <= 1'b0;
         dn_head_o   <= '0;
         dn_data_o   <= '0;
      end else begin
         state_q     <= state_d;
         gap_q       <= gap_d;
         acc_q       <= acc_d;
         dn_valid_o  <= vld_d;
         dn_marker_o <= mk_d;
         dn_head_o   <= head_d;
         dn_data_o   <= data_d;
      end
   end

endmodule

// File: tb/tb_am_insert_sched.sv
// Bench for am_insert_sched with a 15-beat marker interval.
// Expected downstream stream is rebuilt from accepted upstream beats and the marker/BIP rules.
// Hand-computed marker words pin the model at reset, after a zero interval and after a mid-interval reset.
module tb_am_insert_sched;

   typedef logic [287:0] w_t;
   typedef struct packed {
      logic [7:0]   h;
      logic [255:0] d;
   } beat_t;

   logic         clk;
   logic         reset;
   logic         up_valid;
   logic         up_ready_o;
   logic [7:0]   up_head;
   logic [255:0] up_data;
   logic         dn_valid_o;
   logic         dn_ready;
   logic [7:0]   dn_head_o;
   logic [255:0] dn_data_o;
   logic         dn_marker_o;

   int checks = 0;
   int errors = 0;
   int seq;
   bit took;

   // model state
   beat_t        q[$];
   int           pos;
   logic [7:0]   acc [4];
   bit           hold_vld;
   logic [264:0] hold_bt;
   logic [7:0]   mk_tab [4][6] = '{'{8'h90, 8'h76, 8'h47, 8'h6F, 8'h89, 8'hB8},
                                   '{8'hF0, 8'hC4, 8'hE6, 8'h0F, 8'h3B, 8'h19},
                                   '{8'hC5, 8'h65, 8'h9B, 8'h3A, 8'h9A, 8'h64},
                                   '{8'hA2, 8'h79, 8'h3D, 8'h5D, 8'h86, 8'hC2}};

   am_insert_sched #(
      .LANE_N(4),
      .HEAD_W(2),
      .DATA_W(64),
      .GAP_W (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .up_valid_i (up_valid),
      .up_ready_o (up_ready_o),
      .up_head_i  (up_head),
      .up_data_i  (up_data),
      .dn_valid_o (dn_valid_o),
      .dn_ready_i (dn_ready),
      .dn_head_o  (dn_head_o),
      .dn_data_o  (dn_data_o),
      .dn_marker_o(dn_marker_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input w_t act, input w_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   // Block parity straight from the bit-numbering rule: b0/b1 header, b(k+2) payload.
   function automatic logic [7:0] mfold(input logic [1:0] h, input logic [63:0] d);
      logic [65:0] b;
      logic [7:0]  f;
      b = {d, h};
      f = '0;
      for (int j = 0; j < 8; j++) begin
         for (int n = j + 2; n < 66; n += 8) begin
            f[j] = f[j] ^ b[n];
         end
      end
      f[3] = f[3] ^ b[0];
      f[4] = f[4] ^ b[1];
      return f;
   endfunction

   // One downstream transfer: slot 0 of each 16-beat period is a marker, the rest are upstream beats in order.
   task automatic model_xfer();
      logic [7:0]   eh;
      logic [255:0] ed;
      logic         em;
      beat_t        b;
      logic [63:0]  d;
      eh = '0;
      ed = '0;
      if (pos == 0) begin
         em = 1'b1;
         for (int l = 0; l < 4; l++) begin
            d = {~acc[l], mk_tab[l][5], mk_tab[l][4], mk_tab[l][3],
                 acc[l], mk_tab[l][2], mk_tab[l][1], mk_tab[l][0]};
            eh[l*2 +: 2]  = 2'b01;
            ed[l*64 +: 64] = d;
            acc[l] = mfold(2'b01, d);
         end
      end else begin
         em = 1'b0;
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL model_queue data beat out with none accepted act=0 exp=1");
         end else begin
            b  = q.pop_front();
            eh = b.h;
            ed = b.d;
            for (int l = 0; l < 4; l++) begin
               acc[l] = acc[l] ^ mfold(b.h[l*2 +: 2], b.d[l*64 +: 64]);
            end
         end
      end
      chk("dn_beat", w_t'({dn_marker_o, dn_head_o, dn_data_o}), w_t'({em, eh, ed}));
      pos = (pos == 15) ? 0 : pos + 1;
   endtask

   // Compare process: looks at the handshakes that will complete at the coming rising edge.
   always @(negedge clk) begin
      if (reset) begin
         q.delete();
         pos = 0;
         for (int l = 0; l < 4; l++) acc[l] = 8'h00;
         hold_vld = 1'b0;
         took = 1'b0;
      end else begin
         if (hold_vld) begin
            chk("hold_stable", w_t'({dn_valid_o, dn_marker_o, dn_head_o, dn_data_o}), w_t'({1'b1, hold_bt}));
         end
         if (dn_valid_o && !dn_ready) begin
            chk("stall_up_ready", w_t'(up_ready_o), w_t'(1'b0));
            hold_vld = 1'b1;
            hold_bt  = {dn_marker_o, dn_head_o, dn_data_o};
         end else begin
            hold_vld = 1'b0;
         end
         if (dn_valid_o && dn_ready) model_xfer();
         if (up_valid && up_ready_o) begin
            q.push_back(beat_t'({up_head, up_data}));
            took = 1'b1;
         end
      end
   end

   // First 15 beats are zero payload with header 2'b10 on every lane, later beats are random.
   task automatic new_beat();
      if (seq < 15) begin
         up_head = 8'hAA;
         up_data = '0;
      end else begin
         up_head = 8'($urandom);
         up_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
   endtask

   task automatic cyc(input bit v, input bit r);
      @(posedge clk);
      #1;
      if (took) begin
         took = 1'b0;
         seq++;
         new_beat();
      end
      up_valid = v;
      dn_ready = r;
   endtask

   task automatic wait_mark(input string name);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         cyc(1'b1, 1'b1);
         @(negedge clk);
         if (dn_valid_o && dn_ready && dn_marker_o) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL %s no marker within 200 cycles act=0 exp=1", name);
      end
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, "_dn_valid"}, w_t'(dn_valid_o), w_t'(1'b0));
      chk({name, "_dn_marker"}, w_t'(dn_marker_o), w_t'(1'b0));
      chk({name, "_up_ready"}, w_t'(up_ready_o), w_t'(1'b0));
      chk({name, "_dn_head"}, w_t'(dn_head_o), w_t'(8'h00));
      chk({name, "_dn_data"}, w_t'(dn_data_o), w_t'(256'h0));
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout act=running exp=finished");
      $fatal(1);
   end

   initial begin
      reset    = 1'b1;
      up_valid = 1'b1;
      dn_ready = 1'b1;
      seq      = 0;
      took     = 1'b0;
      new_beat();
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("rst");
      @(posedge clk);
      #1 reset = 1'b0;

      // Marker slot right after reset: upstream is not taken.
      @(negedge clk);
      chk("am0_slot_up_ready", w_t'(up_ready_o), w_t'(1'b0));
      cyc(1'b1, 1'b1);
      @(negedge clk);
      chk("am0_marker", w_t'(dn_marker_o), w_t'(1'b1));
      chk("am0_lane0_data", w_t'(dn_data_o[63:0]), w_t'(64'hFFB8896F00477690));
      chk("am0_lane0_head", w_t'(dn_head_o[1:0]), w_t'(2'b01));
      chk("am0_lane3_data", w_t'(dn_data_o[255:192]), w_t'(64'hFFC2865D003D79A2));

      // After 15 zero beats with header 2'b10 every lane's BIP is 0x08 ^ 0x10.
      wait_mark("am1");
      chk("am1_lane0_data", w_t'(dn_data_o[63:0]), w_t'(64'hE7B8896F18477690));
      chk("am1_lane1_data", w_t'(dn_data_o[127:64]), w_t'(64'hE7193B0F18E6C4F0));
      wait_mark("am2");

      // Downstream stall for five cycles mid-interval.
      repeat (4) cyc(1'b1, 1'b1);
      repeat (5) cyc(1'b1, 1'b0);
      repeat (4) cyc(1'b1, 1'b1);

      // Upstream valid toggling every cycle.
      for (int c = 0; c < 60; c++) cyc(c % 2 == 0, 1'b1);
      wait_mark("am_toggle");

      // Reset pulse a few data beats into an interval.
      repeat (7) cyc(1'b1, 1'b1);
      cyc(1'b1, 1'b1);
      reset = 1'b1;
      #1;
      chk_reset_outputs("mid_rst");
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("post_rst_slot_dn_valid", w_t'(dn_valid_o), w_t'(1'b0));
      cyc(1'b1, 1'b1);
      @(negedge clk);
      chk("post_rst_marker", w_t'(dn_marker_o), w_t'(1'b1));
      chk("post_rst_lane0_data", w_t'(dn_data_o[63:0]), w_t'(64'hFFB8896F00477690));
      chk("post_rst_lane2_data", w_t'(dn_data_o[191:128]), w_t'(64'hFF649A3A009B65C5));

      // Mixed random valid and backpressure.
      for (int c = 0; c < 400; c++) cyc(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      repeat (8) cyc(1'b0, 1'b1);
      @(negedge clk);
      chk("drain_queue_empty", w_t'(q.size()), w_t'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
